// File: rtl/spart_bus_arbiter_if.sv
// Requester-side handshake between two bus drivers and the SPART arbiter.
// master = requester side, slave = arbiter side.
interface spart_bus_arbiter_if;
    logic       req0;
    logic       req1;
    logic       rw0;
    logic       rw1;
    logic [7:0] wdata0;
    logic [7:0] wdata1;
    logic       gnt0;
    logic       gnt1;
    logic       done0;
    logic       done1;
    logic [7:0] rdata;
    logic       err;

    modport master (
        output req0, req1, rw0, rw1, wdata0, wdata1,
        input  gnt0, gnt1, done0, done1, rdata, err
    );

    modport slave (
        input  req0, req1, rw0, rw1, wdata0, wdata1,
        output gnt0, gnt1, done0, done1, rdata, err
    );
endinterface

// File: rtl/spart_bus_arbiter.sv
// Shares one SPART processor bus between two requesters, programming the baud divisor first.
// Optional wait-for-ready abort: define ARB_TIMEOUT_EN.
module spart_bus_arbiter #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [15:0]        divisor,
    input  logic               cfg_req,
    output logic               cfg_busy,
    spart_bus_arbiter_if.slave rq,
    output logic               iocs,
    output logic               iorw,
    output logic [1:0]         ioaddr,
    inout  wire  [7:0]         databus,
    input  logic               rda,
    input  logic               tbr
);

    typedef enum logic [2:0] {
        BOOT,
        CFG_LO,
        CFG_HI,
        IDLE,
        WAIT_RDY,
        XFER,
        DONE
    } state_t;

    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t     state;
    logic       ptr;
    logic       gnt0;
    logic       gnt1;
    logic       done0;
    logic       done1;
    logic [7:0] rdata_q;

    logic       sel_rw;
    logic       sel_req;
    logic       sel_rdy;
    logic [7:0] sel_wdata;
    logic       win;
    logic [7:0] dout;

    // The granted requester is identified by its registered gnt.
    assign sel_rw    = gnt1 ? rq.rw1 : rq.rw0;
    assign sel_req   = gnt1 ? rq.req1 : rq.req0;
    assign sel_wdata = gnt1 ? rq.wdata1 : rq.wdata0;
    assign sel_rdy   = sel_rw ? rda : tbr;
    assign win       = (rq.req0 & rq.req1) ? ~ptr : rq.req1;

`ifdef ARB_TIMEOUT_EN
    logic [15:0] wait_cnt;
    logic        err_q;
    assign rq.err = err_q;
`else
    logic unused_timeout;
    assign unused_timeout = ^TO_LAST;
    assign rq.err = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= BOOT;
            ptr      <= 1'b1;
            gnt0     <= 1'b0;
            gnt1     <= 1'b0;
            done0    <= 1'b0;
            done1    <= 1'b0;
            rdata_q  <= 8'h00;
            cfg_busy <= 1'b1;
`ifdef ARB_TIMEOUT_EN
            wait_cnt <= '0;
            err_q    <= 1'b0;
`endif
        end else begin
            done0 <= 1'b0;
            done1 <= 1'b0;
            unique case (state)
                BOOT:   state <= CFG_LO;
                CFG_LO: state <= CFG_HI;
                CFG_HI: begin
                    state    <= IDLE;
                    cfg_busy <= 1'b0;
                end
                IDLE: begin
                    if (cfg_req) begin
                        state    <= CFG_LO;
                        cfg_busy <= 1'b1;
                    end else if (rq.req0 | rq.req1) begin
                        gnt0  <= ~win;
                        gnt1  <= win;
                        ptr   <= win;
                        state <= WAIT_RDY;
`ifdef ARB_TIMEOUT_EN
                        wait_cnt <= '0;
`endif
                    end
                end
                WAIT_RDY: begin
                    if (!sel_req) begin
                        state <= IDLE;
                        gnt0  <= 1'b0;
                        gnt1  <= 1'b0;
                    end else if (sel_rdy) begin
                        state <= XFER;
`ifdef ARB_TIMEOUT_EN
                    end else if (wait_cnt == TO_LAST) begin
                        state <= DONE;
                        done0 <= gnt0;
                        done1 <= gnt1;
                        err_q <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 16'd1;
`endif
                    end
                end
                XFER: begin
                    state <= DONE;
                    done0 <= gnt0;
                    done1 <= gnt1;
`ifdef ARB_TIMEOUT_EN
                    err_q <= 1'b0;
`endif
                    if (sel_rw) rdata_q <= databus;
                end
                DONE: begin
                    state <= IDLE;
                    gnt0  <= 1'b0;
                    gnt1  <= 1'b0;
                end
                default: state <= BOOT;
            endcase
        end
    end

    always_comb begin
        iocs   = 1'b0;
        iorw   = 1'b1;
        ioaddr = 2'b00;
        dout   = 8'h00;
        unique case (state)
            CFG_LO: begin
                iocs   = 1'b1;
                iorw   = 1'b0;
                ioaddr = 2'b10;
                dout   = divisor[7:0];
            end
            CFG_HI: begin
                iocs   = 1'b1;
                iorw   = 1'b0;
                ioaddr = 2'b11;
                dout   = divisor[15:8];
            end
            XFER: begin
                iocs = 1'b1;
                iorw = sel_rw;
                dout = sel_wdata;
            end
            default: ;
        endcase
    end

    assign databus  = (iocs && !iorw) ? dout : 8'hzz;
    assign rq.gnt0  = gnt0;
    assign rq.gnt1  = gnt1;
    assign rq.done0 = done0;
    assign rq.done1 = done1;
    assign rq.rdata = rdata_q;

endmodule

// File: tb/tb_spart_bus_arbiter.sv
// Directed bench for spart_bus_arbiter: vector table plus multi-cycle sequences.
// Timeout scenario runs only when ARB_TIMEOUT_EN is defined.
module tb_spart_bus_arbiter;

    localparam int TO = 1024;

    logic        clk;
    logic        rst;
    logic [15:0] divisor;
    logic        cfg_req;
    logic        cfg_busy;
    logic        iocs;
    logic        iorw;
    logic [1:0]  ioaddr;
    wire  [7:0]  databus;
    logic        rda;
    logic        tbr;
    logic [7:0]  spart_rx;

    spart_bus_arbiter_if rq();

    spart_bus_arbiter dut (
        .clk      (clk),
        .rst      (rst),
        .divisor  (divisor),
        .cfg_req  (cfg_req),
        .cfg_busy (cfg_busy),
        .rq       (rq.slave),
        .iocs     (iocs),
        .iorw     (iorw),
        .ioaddr   (ioaddr),
        .databus  (databus),
        .rda      (rda),
        .tbr      (tbr)
    );

    // SPART model answers reads only.
    assign databus = (iocs && iorw) ? spart_rx : 8'hzz;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_err = 0;
    int n_chk = 0;

    task automatic chk(input string nm, input logic [15:0] act,
                       input logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    typedef struct {
        logic       req0, req1, rw0, rw1, tbr, rda;
        logic [7:0] wd0;
        logic       iocs, iorw;
        logic [1:0] addr;
        logic [7:0] bus;
        logic       gnt0, gnt1, done0, done1, busy;
    } vec_t;

    vec_t vt[11];

    int   n_srv;
    int   bad;
    logic order[4];
    int   n_at;
    int   n_xf;
    logic got;

    initial begin
        vt[0]  = '{0,0,0,0,0,0,8'h00, 1,0,2'b10,8'hA3, 0,0,0,0,1};
        vt[1]  = '{0,0,0,0,0,0,8'h00, 1,0,2'b11,8'h27, 0,0,0,0,1};
        vt[2]  = '{0,0,0,0,0,0,8'h00, 0,1,2'b00,8'h00, 0,0,0,0,0};
        vt[3]  = '{1,0,0,0,1,0,8'h48, 0,1,2'b00,8'h00, 1,0,0,0,0};
        vt[4]  = '{1,0,0,0,1,0,8'h48, 1,0,2'b00,8'h48, 1,0,0,0,0};
        vt[5]  = '{1,0,0,0,1,0,8'h48, 0,1,2'b00,8'h00, 1,0,1,0,0};
        vt[6]  = '{0,0,0,0,1,0,8'h48, 0,1,2'b00,8'h00, 0,0,0,0,0};
        vt[7]  = '{0,0,0,0,1,0,8'h48, 0,1,2'b00,8'h00, 0,0,0,0,0};
        vt[8]  = '{0,1,0,1,1,0,8'h00, 0,1,2'b00,8'h00, 0,1,0,0,0};
        vt[9]  = '{0,0,0,1,1,0,8'h00, 0,1,2'b00,8'h00, 0,0,0,0,0};
        vt[10] = '{0,0,0,1,1,0,8'h00, 0,1,2'b00,8'h00, 0,0,0,0,0};

        rst       = 1'b1;
        divisor   = 16'h27A3;
        cfg_req   = 1'b0;
        rda       = 1'b0;
        tbr       = 1'b0;
        spart_rx  = 8'h00;
        rq.req0   = 1'b0;
        rq.req1   = 1'b0;
        rq.rw0    = 1'b0;
        rq.rw1    = 1'b0;
        rq.wdata0 = 8'h00;
        rq.wdata1 = 8'h00;

        // Reset state
        tick();
        tick();
        chk("rst.iocs", 16'(iocs), 16'd0);
        chk("rst.iorw", 16'(iorw), 16'd1);
        chk("rst.addr", 16'(ioaddr), 16'd0);
        chk("rst.gnt", 16'({rq.gnt0, rq.gnt1}), 16'd0);
        chk("rst.done", 16'({rq.done0, rq.done1}), 16'd0);
        chk("rst.rdata", 16'(rq.rdata), 16'h00);
        chk("rst.err", 16'(rq.err), 16'd0);
        chk("rst.busy", 16'(cfg_busy), 16'd1);

        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("boot.iocs", 16'(iocs), 16'd0);
        chk("boot.busy", 16'(cfg_busy), 16'd1);

        // Config sequence, TX write, request withdrawn in WAIT_RDY
        for (int i = 0; i < 11; i++) begin
            rq.req0   = vt[i].req0;
            rq.req1   = vt[i].req1;
            rq.rw0    = vt[i].rw0;
            rq.rw1    = vt[i].rw1;
            rq.wdata0 = vt[i].wd0;
            tbr       = vt[i].tbr;
            rda       = vt[i].rda;
            tick();
            chk($sformatf("v%0d.iocs", i), 16'(iocs), 16'(vt[i].iocs));
            chk($sformatf("v%0d.iorw", i), 16'(iorw), 16'(vt[i].iorw));
            chk($sformatf("v%0d.addr", i), 16'(ioaddr), 16'(vt[i].addr));
            if (vt[i].iocs && !vt[i].iorw)
                chk($sformatf("v%0d.bus", i), 16'(databus),
                    16'(vt[i].bus));
            chk($sformatf("v%0d.gnt0", i), 16'(rq.gnt0), 16'(vt[i].gnt0));
            chk($sformatf("v%0d.gnt1", i), 16'(rq.gnt1), 16'(vt[i].gnt1));
            chk($sformatf("v%0d.done0", i), 16'(rq.done0),
                16'(vt[i].done0));
            chk($sformatf("v%0d.done1", i), 16'(rq.done1),
                16'(vt[i].done1));
            chk($sformatf("v%0d.busy", i), 16'(cfg_busy), 16'(vt[i].busy));
        end

        // RX read after a 20-cycle rda wait
        spart_rx = 8'h48;
        rq.req1  = 1'b1;
        rq.rw1   = 1'b1;
        rda      = 1'b0;
        bad      = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (iocs !== 1'b0 || rq.done1 !== 1'b0) bad++;
        end
        chk("rx.wait_idle", 16'(bad), 16'd0);
        chk("rx.gnt1", 16'(rq.gnt1), 16'd1);
        rda = 1'b1;
        tick();
        chk("rx.xfer", 16'({iocs, iorw, ioaddr}), 16'b1100);
        tick();
        chk("rx.done1", 16'(rq.done1), 16'd1);
        chk("rx.done0", 16'(rq.done0), 16'd0);
        chk("rx.rdata", 16'(rq.rdata), 16'h48);
        rq.req1 = 1'b0;
        rda     = 1'b0;
        tick();
        chk("rx.gnt_clr", 16'(rq.gnt1), 16'd0);
        spart_rx = 8'h00;

        // Both requesters held: service alternates
        rq.rw0    = 1'b0;
        rq.rw1    = 1'b0;
        rq.wdata0 = 8'h11;
        rq.wdata1 = 8'h22;
        tbr       = 1'b1;
        rq.req0   = 1'b1;
        rq.req1   = 1'b1;
        n_srv     = 0;
        bad       = 0;
        for (int k = 0; k < 4; k++) order[k] = 1'bx;
        for (int c = 0; c < 40 && n_srv < 4; c++) begin
            tick();
            if (rq.gnt0 && rq.gnt1) bad++;
            if (rq.done0 && rq.done1) bad++;
            if (iocs && !iorw && databus !== (rq.gnt1 ? 8'h22 : 8'h11))
                bad++;
            if (rq.done0 ^ rq.done1) begin
                order[n_srv] = rq.done1;
                n_srv++;
            end
        end
        rq.req0 = 1'b0;
        rq.req1 = 1'b0;
        chk("rr.count", 16'(n_srv), 16'd4);
        chk("rr.excl", 16'(bad), 16'd0);
        for (int k = 0; k < 4; k++)
            chk($sformatf("rr.order%0d", k), 16'(order[k]), 16'(k % 2));
        tick();
        tick();
        chk("rr.idle", 16'({rq.gnt0, rq.gnt1}), 16'd0);

        // cfg_req and req0 together: configuration first
        divisor   = 16'h0145;
        cfg_req   = 1'b1;
        rq.req0   = 1'b1;
        rq.wdata0 = 8'h5A;
        tick();
        cfg_req = 1'b0;
        chk("cf.lo", 16'({iocs, iorw, ioaddr}), 16'b1010);
        chk("cf.lo_bus", 16'(databus), 16'h45);
        chk("cf.busy", 16'(cfg_busy), 16'd1);
        chk("cf.gnt0", 16'(rq.gnt0), 16'd0);
        tick();
        chk("cf.hi", 16'({iocs, iorw, ioaddr}), 16'b1011);
        chk("cf.hi_bus", 16'(databus), 16'h01);
        tick();
        chk("cf.busy_clr", 16'(cfg_busy), 16'd0);
        tick();
        chk("cf.gnt_late", 16'(rq.gnt0), 16'd1);
        tick();
        chk("cf.xfer_bus", 16'(databus), 16'h5A);
        tick();
        chk("cf.done0", 16'(rq.done0), 16'd1);
        rq.req0 = 1'b0;
        tick();

        // Reset pulsed mid-transfer
        rq.req0   = 1'b1;
        rq.wdata0 = 8'h77;
        tick();
        tick();
        chk("rx6.in_xfer", 16'(iocs), 16'd1);
        #1 rst = 1'b1;
        #1;
        chk("r6.iocs", 16'(iocs), 16'd0);
        chk("r6.iorw", 16'(iorw), 16'd1);
        chk("r6.gnt0", 16'(rq.gnt0), 16'd0);
        chk("r6.busy", 16'(cfg_busy), 16'd1);
        rq.req0 = 1'b0;
        @(posedge clk);
        #1;
        chk("r6.nodone", 16'(rq.done0), 16'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("r6.boot", 16'(iocs), 16'd0);
        tick();
        chk("r6.cfg_lo", 16'({iocs, iorw, ioaddr}), 16'b1010);
        chk("r6.cfg_bus", 16'(databus), 16'h45);
        tick();
        tick();
        chk("r6.busy_clr", 16'(cfg_busy), 16'd0);

`ifdef ARB_TIMEOUT_EN
        // tbr stuck low: abort with err after TO cycles in WAIT_RDY
        tbr     = 1'b0;
        rq.rw0  = 1'b0;
        rq.req0 = 1'b1;
        n_at    = 0;
        n_xf    = 0;
        got     = 1'b0;
        for (int c = 1; c <= TO + 100 && !got; c++) begin
            tick();
            if (iocs) n_xf++;
            if (rq.done0) begin
                got  = 1'b1;
                n_at = c;
                chk("to.err", 16'(rq.err), 16'd1);
            end
        end
        rq.req0 = 1'b0;
        chk("to.got", 16'(got), 16'd1);
        chk("to.cycle", 16'(n_at), 16'(TO + 1));
        chk("to.noxfer", 16'(n_xf), 16'd0);
        tick();
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
